// File: rtl/bcd_display_scanner.sv
// Time-multiplexes NUM_DIGITS captured BCD digits onto one 7-segment display, one slot per PRESCALE cycles.
// Outputs are registered one cycle behind the scan; new digits take effect only at a frame wrap or while disabled.
module bcd_display_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE      = 4,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    invalid
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    invalid_q, invalid_d;

    logic       tick, wrap;
    logic [3:0] cur_digit;
    logic       upper_nz, blank;
    logic [6:0] seg_act;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        tick = enable && (presc_q == PRESC_LAST);
        wrap = tick && (idx_q == IDX_LAST);

        presc_d = presc_q;
        if (enable)
            presc_d = tick ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (tick)
            idx_d = wrap ? '0 : idx_q + 1'b1;

        pending_d = load ? digits_in : pending_q;
        // Shadow samples the value pending before this edge, so a load coinciding with a wrap waits a frame.
        shadow_d  = (wrap || !enable) ? pending_q : shadow_q;
        frame_done_d = wrap;
    end

    always_comb begin
        invalid_d = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (shadow_d[4*k +: 4] > 4'd9)
                invalid_d = 1'b1;
    end

    always_comb begin
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_q)
                cur_digit = shadow_q[4*k +: 4];
            if (IW'(k) >= idx_q && shadow_q[4*k +: 4] != 4'd0)
                upper_nz = 1'b1;
        end
        // A slot is a leading zero when it and every more significant digit are zero.
        blank   = BLANK_LEADING && (idx_q != '0) && !upper_nz;
        seg_act = blank ? 7'h00 : decode(cur_digit);
        seg_d   = enable ? (seg_act ^ SEG_OFF) : SEG_OFF;
        an_d    = enable ? ((NUM_DIGITS'(1) << idx_q) ^ AN_OFF) : AN_OFF;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            shadow_q     <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            invalid_q    <= invalid_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign invalid    = invalid_q;
endmodule
